// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit boundary: instruction-register fields and flags in, datapath selects/enables out.
// master = control FSM, slave = datapath/memory side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath (shared ALU, unified memory).
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_ctrl_if.master      bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    state_t     state, state_n;
    logic       is_sw_q, is_bne_q;
    logic       mem_go;
    logic [3:0] r_alu, i_alu;
    logic       r_ok;
    logic       pc_write, branch, bne;
    logic       ir_write, mem_write, reg_write;

`ifdef MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (bus.funct)
            6'b100000, 6'b100001: r_alu = ALU_ADD;
            6'b100010, 6'b100011: r_alu = ALU_SUB;
            6'b100100:            r_alu = ALU_AND;
            6'b100101:            r_alu = ALU_OR;
            6'b100110:            r_alu = ALU_XOR;
            6'b100111:            r_alu = ALU_NOR;
            6'b101010:            r_alu = ALU_SLT;
            6'b101011:            r_alu = ALU_SLTU;
            6'b000000:            r_alu = ALU_SLL;
            6'b000010:            r_alu = ALU_SRL;
            6'b000011:            r_alu = ALU_SRA;
            6'b000100:            r_alu = ALU_SLLV;
            6'b000110:            r_alu = ALU_SRLV;
            6'b000111:            r_alu = ALU_SRAV;
            default:              r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        case (bus.opcode)
            OP_ANDI:  i_alu = ALU_AND;
            OP_ORI:   i_alu = ALU_OR;
            OP_XORI:  i_alu = ALU_XOR;
            OP_SLTI:  i_alu = ALU_SLT;
            OP_SLTIU: i_alu = ALU_SLTU;
            OP_LUI:   i_alu = ALU_LUI;
            default:  i_alu = ALU_ADD;
        endcase
    end

    // Load/store and beq/bne flavour are captured in DECODE so later states depend only on state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            is_sw_q  <= 1'b0;
            is_bne_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                is_sw_q  <= (bus.opcode == OP_SW);
                is_bne_q <= (bus.opcode == OP_BNE);
            end
        end
    end

    always_comb begin
        state_n         = state;
        pc_write        = 1'b0;
        branch          = 1'b0;
        bne             = 1'b0;
        ir_write        = 1'b0;
        mem_write       = 1'b0;
        reg_write       = 1'b0;
        bus.iord        = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_src      = 2'b00;
        bus.alu_control = ALU_ADD;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        case (state)
            FETCH: begin
                bus.alu_src_b = 2'b01;
                if (mem_go) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:  state_n = MEMADR;
                    OP_RTYPE:      state_n = r_ok ? EXEC : FETCH;
                    OP_BEQ, OP_BNE: state_n = BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU, OP_LUI: state_n = IEXEC;
                    OP_J:          state_n = JUMP;
                    default:       state_n = FETCH;
                endcase
                if (state_n == FETCH) begin
                    bus.illegal_op = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_n       = is_sw_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.iord = 1'b1;
                if (mem_go) state_n = MEMWB;
            end
            MEMWB: begin
                reg_write      = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                state_n        = FETCH;
            end
            MEMWR: begin
                bus.iord  = 1'b1;
                mem_write = 1'b1;
                if (mem_go) begin
                    bus.instr_done = 1'b1;
                    state_n        = FETCH;
                end
            end
            EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = r_alu;
                state_n         = ALUWB;
            end
            ALUWB: begin
                reg_write      = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                state_n        = FETCH;
            end
            IEXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = i_alu;
                state_n         = IWB;
            end
            IWB: begin
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
                state_n        = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                branch          = 1'b1;
                bne             = is_bne_q;
                bus.pc_src      = 2'b01;
                bus.instr_done  = 1'b1;
                state_n         = FETCH;
            end
            JUMP: begin
                pc_write       = 1'b1;
                bus.pc_src     = 2'b10;
                bus.instr_done = 1'b1;
                state_n        = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Enables are suppressed for the whole reset pulse so an abandoned instruction leaves no writes.
    assign bus.pc_en     = ~reset & (pc_write | (branch & (bus.zero ^ bne)));
    assign bus.ir_write  = ~reset & ir_write;
    assign bus.mem_write = ~reset & mem_write;
    assign bus.reg_write = ~reset & reg_write;
endmodule
